fmap_buffer: RTL and testbench

- Downstream stage of the conv/activation/pool layer.
- Captures the pooled output stream (valid_op/data_out/end_op) into a single-port feature-map RAM.
- Then replays the complete map in raster order, under a ready/valid handshake, to the next layer's pixel input.
- Fill and drain alternate; the block never writes and reads the same map concurrently.

---
 rtl/fmap_pkg.sv | 30 +++
 rtl/fmap_ram.sv | 45 ++++
 rtl/fmap_buffer.sv | 220 ++++++++++++++++++++++
 tb/tb_fmap_buffer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmap_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fmap_pkg                                                     |
// | Description : Shared types and helpers for the feature-map buffer.         |
// |               - fmap_state_t : controller state (FILL / PRIME / DRAIN)     |
// |               - fmap_clog2   : ceil(log2(n)), never less than 1, used to   |
// |                                size addresses and counters                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fmap_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      PRIME = 2'd1,
      DRAIN = 2'd2
   } fmap_state_t;

   // Minimum of 1 keeps degenerate single-element maps from producing
   // zero-width vectors.
   function automatic int fmap_clog2(input int value);
      int result;
      result = 1;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fmap_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fmap_ram                                                     |
// | Description : Single-port synchronous feature-map RAM with a registered    |
// |               read port. A write has priority over a read in the same      |
// |               cycle. The read register only updates when i_re is high, so  |
// |               o_rdata holds its value across idle cycles.                  |
// | Ports       : clk     - clock                                              |
// |               i_we    - write enable                                       |
// |               i_re    - read enable (ignored while i_we is high)           |
// |               i_addr  - shared read/write address                          |
// |               i_wdata - write data                                         |
// |               o_rdata - registered read data                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fmap_ram #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 169,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_q;

   // Contents are deliberately not reset: a reset only aborts the current
   // map, it never wipes stored data.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end else if (i_re) begin
         r_q <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/fmap_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fmap_buffer                                                  |
// | Description : Captures a pooled feature map into a single-port RAM, then   |
// |               replays it in raster order over a ready/valid interface.     |
// |               Fill and drain alternate and never overlap.                  |
// | Option      : FMAP_ZERO_PAD_EN - when defined, the drain emits a one-      |
// |               element zero border around the map ((MAP_SIZE+2)^2 outputs). |
// | Ports       : clk        - clock, rising edge                              |
// |               global_rst - synchronous reset, active low                   |
// |               wr_valid   - element strobe from the pooler                  |
// |               wr_data    - element value                                   |
// |               wr_end     - producer end-of-map (short map)                 |
// |               rd_ready   - downstream accepts rd_data                      |
// |               rd_data    - replayed element                                |
// |               rd_valid   - rd_data valid                                   |
// |               rd_last    - final element of the replayed map               |
// |               count      - elements captured in the current map            |
// |               overflow   - sticky: write arrived outside FILL              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fmap_buffer
   import fmap_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   parameter  int MAP_SIZE   = 13,
   localparam int DEPTH      = MAP_SIZE * MAP_SIZE,
   localparam int ADDR_WIDTH = fmap_clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  global_rst,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_end,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_last,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow
);

   localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   c_CNT_ONE   = (ADDR_WIDTH + 1)'(1);

   fmap_state_t           r_state;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_overflow;

   // Prefetch stage: one element fetched ahead of the presented output so
   // that an accept can be followed by the next element without a bubble.
   logic                  r_pf_valid;
   logic                  r_pf_zero;
   logic                  r_pf_last;
   logic                  r_src_done;

   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_valid;
   logic                  r_rd_last;

   logic                  w_wr_fire;
   logic                  w_map_done;
   logic                  w_accept;
   logic                  w_load;
   logic                  w_fetch;
   logic                  w_src_zero;
   logic                  w_src_last;
   logic                  w_ram_re;
   logic [ADDR_WIDTH:0]   w_count_inc;
   logic [ADDR_WIDTH-1:0] w_ram_addr;
   logic [DATA_WIDTH-1:0] w_ram_q;

   assign w_wr_fire   = (r_state == FILL) && wr_valid;
   assign w_count_inc = r_count + {{ADDR_WIDTH{1'b0}}, wr_valid};

   // A map completes on the write into the last slot, or on wr_end once at
   // least one element (including a same-cycle write) has been captured.
   assign w_map_done  = (r_state == FILL) &&
                        ((wr_valid && (r_wr_ptr == c_LAST_ADDR)) ||
                         (wr_end && (w_count_inc != '0)));

   assign w_accept    = r_rd_valid && rd_ready;
   assign w_load      = r_pf_valid && (!r_rd_valid || rd_ready);
   assign w_fetch     = (r_state != FILL) && !r_src_done && (!r_pf_valid || w_load);

   // Border positions never touch the RAM; its read register then keeps the
   // last interior value, which the zero flag masks at load time.
   assign w_ram_re    = w_fetch && !w_src_zero;
   assign w_ram_addr  = (r_state == FILL) ? r_wr_ptr : r_rd_ptr;

`ifdef FMAP_ZERO_PAD_EN
   localparam int                  RC_WIDTH  = fmap_clog2(MAP_SIZE + 2);
   localparam logic [RC_WIDTH-1:0] c_RC_LAST = RC_WIDTH'(MAP_SIZE + 1);
   localparam logic [RC_WIDTH-1:0] c_RC_ONE  = RC_WIDTH'(1);

   logic [RC_WIDTH-1:0] r_row;
   logic [RC_WIDTH-1:0] r_col;

   assign w_src_zero = (r_row == '0) || (r_row == c_RC_LAST) ||
                       (r_col == '0) || (r_col == c_RC_LAST);
   assign w_src_last = (r_row == c_RC_LAST) && (r_col == c_RC_LAST);
`else
   assign w_src_zero = 1'b0;
   assign w_src_last = ({1'b0, r_rd_ptr} == (r_count - c_CNT_ONE));
`endif

   fmap_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_wr_fire),
      .i_re    (w_ram_re),
      .i_addr  (w_ram_addr),
      .i_wdata (wr_data),
      .o_rdata (w_ram_q)
   );

   always_ff @(posedge clk) begin
      if (!global_rst) begin
         r_state    <= FILL;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_pf_valid <= 1'b0;
         r_pf_zero  <= 1'b0;
         r_pf_last  <= 1'b0;
         r_src_done <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
`ifdef FMAP_ZERO_PAD_EN
         r_row      <= '0;
         r_col      <= '0;
`endif
      end else begin
         // Controller state
         case (r_state)
            FILL: begin
               if (w_wr_fire) begin
                  r_wr_ptr <= r_wr_ptr + c_ADDR_ONE;
                  r_count  <= w_count_inc;
               end
               if (w_map_done) begin
                  r_state    <= PRIME;
                  r_rd_ptr   <= '0;
                  r_src_done <= 1'b0;
`ifdef FMAP_ZERO_PAD_EN
                  r_row      <= '0;
                  r_col      <= '0;
`endif
               end
            end
            PRIME: begin
               // The first fetch happens here through the prefetch logic.
               r_state <= DRAIN;
            end
            DRAIN: begin
               if (w_accept && r_rd_last) begin
                  r_state  <= FILL;
                  r_wr_ptr <= '0;
                  r_rd_ptr <= '0;
                  r_count  <= '0;
               end
            end
            default: begin
               r_state <= FILL;
            end
         endcase

         if ((r_state != FILL) && wr_valid) begin
            r_overflow <= 1'b1;
         end

         // Prefetch stage
         if (w_fetch) begin
            r_pf_valid <= 1'b1;
            r_pf_zero  <= w_src_zero;
            r_pf_last  <= w_src_last;
            r_src_done <= w_src_last;
            if (!w_src_zero) begin
               r_rd_ptr <= r_rd_ptr + c_ADDR_ONE;
            end
`ifdef FMAP_ZERO_PAD_EN
            if (r_col == c_RC_LAST) begin
               r_col <= '0;
               r_row <= r_row + c_RC_ONE;
            end else begin
               r_col <= r_col + c_RC_ONE;
            end
`endif
         end else if (w_load) begin
            r_pf_valid <= 1'b0;
         end

         // Output register: holds while stalled, refilled on accept.
         if (w_load) begin
            r_rd_data  <= r_pf_zero ? '0 : w_ram_q;
            r_rd_valid <= 1'b1;
            r_rd_last  <= r_pf_last;
         end else if (w_accept) begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
         end
      end
   end

   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign rd_last  = r_rd_last;
   assign count    = r_count;
   assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fmap_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fmap_buffer                                               |
// | Description : Self-checking bench for fmap_buffer (MAP_SIZE=3, 16-bit).   |
// |               Expected drain sequences come from a map-level model of the  |
// |               stored contents; FMAP_ZERO_PAD_EN selects the padded model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fmap_buffer;

   localparam int DW    = 16;
   localparam int MS    = 3;
   localparam int DEPTH = MS * MS;
   localparam int AW    = 4;
   localparam int CW    = AW + 1;

   logic          clk;
   logic          global_rst;
   logic          wr_valid;
   logic [DW-1:0] wr_data;
   logic          wr_end;
   logic          rd_ready;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_last;
   logic [CW-1:0] count;
   logic          overflow;

   int            checks;
   int            errors;
   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] exp_q [$];

   fmap_buffer #(
      .DATA_WIDTH (DW),
      .MAP_SIZE   (MS)
   ) dut (
      .clk        (clk),
      .global_rst (global_rst),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_end     (wr_end),
      .rd_ready   (rd_ready),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_last    (rd_last),
      .count      (count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Expected replay of the current map, built from what was written.
   task automatic build_expected(input int len);
      exp_q.delete();
`ifdef FMAP_ZERO_PAD_EN
      for (int r = 0; r < MS + 2; r++) begin
         for (int c = 0; c < MS + 2; c++) begin
            if (r == 0 || c == 0 || r == MS + 1 || c == MS + 1)
               exp_q.push_back('0);
            else
               exp_q.push_back(model_mem[(r - 1) * MS + (c - 1)]);
         end
      end
`else
      for (int i = 0; i < len; i++) exp_q.push_back(model_mem[i]);
`endif
   endtask

   // end_mode: 0 = no wr_end, 1 = wr_end with last write, 2 = wr_end next cycle.
   // Returns at the first falling edge after the map-completing edge.
   task automatic write_map(input logic [DW-1:0] vals[$], input int end_mode, input bit gaps);
      for (int i = 0; i < vals.size(); i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               wr_valid = 1'b0;
               wr_end   = 1'b0;
            end
         end
         @(negedge clk);
         wr_valid     = 1'b1;
         wr_data      = vals[i];
         wr_end       = (end_mode == 1) && (i == vals.size() - 1);
         model_mem[i] = vals[i];
      end
      if (end_mode == 2) begin
         @(negedge clk);
         wr_valid = 1'b0;
         wr_end   = 1'b1;
      end
      @(negedge clk);
      wr_valid = 1'b0;
      wr_end   = 1'b0;
   endtask

   // ready_mode: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
   task automatic drain_map(input int exp_len, input int ready_mode, input int abort_after,
                            input bit inject_ovf, input string tag);
      int            idx, cyc, acc, n;
      bit            stalled, aborted, r;
      logic [DW-1:0] held_d;
      logic          held_l;
      n = exp_q.size();
      idx = 0; cyc = 0; acc = 0; stalled = 0; aborted = 0;
      held_d = '0; held_l = 1'b0;
      while (idx < n && cyc < 400) begin
         checks++;
         if (cyc < 2 && rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s latency_early cyc=%0d rd_valid=%b want 0", tag, cyc, rd_valid);
         end
         if (cyc == 2) begin
            checks++;
            if (rd_valid !== 1'b1) begin
               errors++;
               $display("FAIL %s latency_first rd_valid=%b want 1", tag, rd_valid);
            end
         end
         if (ready_mode == 0 && cyc > 2) begin
            checks++;
            if (rd_valid !== 1'b1) begin
               errors++;
               $display("FAIL %s bubble cyc=%0d rd_valid=%b want 1", tag, cyc, rd_valid);
            end
         end
         checks++;
         if (count !== CW'(exp_len)) begin
            errors++;
            $display("FAIL %s count_drain got %0d want %0d", tag, count, exp_len);
         end
         if (stalled) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== held_d || rd_last !== held_l) begin
               errors++;
               $display("FAIL %s stall_hold got v=%b d=%h l=%b want v=1 d=%h l=%b",
                        tag, rd_valid, rd_data, rd_last, held_d, held_l);
            end
         end
         case (ready_mode)
            0:       r = 1'b1;
            1:       r = (cyc % 3 == 0);
            default: r = 1'($urandom_range(0, 1));
         endcase
         if (rd_valid === 1'b1 && r) begin
            checks++;
            if (rd_data !== exp_q[idx]) begin
               errors++;
               $display("FAIL %s data[%0d] got %h want %h", tag, idx, rd_data, exp_q[idx]);
            end
            checks++;
            if (rd_last !== (idx == n - 1)) begin
               errors++;
               $display("FAIL %s last[%0d] got %b want %b", tag, idx, rd_last, (idx == n - 1));
            end
            idx++;
            acc++;
            stalled = 0;
         end else if (rd_valid === 1'b1) begin
            stalled = 1;
            held_d  = rd_data;
            held_l  = rd_last;
         end else begin
            stalled = 0;
         end
         rd_ready = r;
         if (inject_ovf && cyc == 4) begin
            wr_valid = 1'b1;
            wr_data  = 16'hAAAA;
         end else begin
            wr_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (abort_after > 0 && acc == abort_after) begin
            aborted = 1;
            break;
         end
      end
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      if (!aborted) begin
         checks++;
         if (idx < n) begin
            errors++;
            $display("FAIL %s timeout got %0d elements want %0d", tag, idx, n);
         end else if (rd_valid !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL %s post_drain got v=%b count=%0d want v=0 count=0", tag, rd_valid, count);
         end
      end
   endtask

   task automatic test_reset;
      global_rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got v=%b l=%b want 0 0", rd_valid, rd_last);
      end
      checks++;
      if (rd_data !== '0) begin
         errors++;
         $display("FAIL reset_data got %h want 0", rd_data);
      end
      checks++;
      if (count !== '0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_count_ovf got count=%0d ovf=%b want 0 0", count, overflow);
      end
      global_rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_map;
      logic [DW-1:0] v [$];
      for (int i = 1; i <= 9; i++) v.push_back(DW'(i));
      write_map(v, 0, 0);
      build_expected(9);
      drain_map(9, 0, 0, 0, "full_map");
   endtask

   task automatic test_backpressure;
      logic [DW-1:0] v [$];
      for (int i = 1; i <= 9; i++) v.push_back(DW'(i));
      write_map(v, 0, 0);
      build_expected(9);
      drain_map(9, 1, 0, 0, "backpressure");
   endtask

   task automatic test_short_map;
      logic [DW-1:0] v [$];
      v = '{16'd5, 16'd6, 16'd7};
      write_map(v, 2, 0);
      build_expected(3);
      drain_map(3, 0, 0, 0, "short_map");
   endtask

   task automatic test_empty_end;
      @(negedge clk);
      wr_end = 1'b1;
      @(negedge clk);
      wr_end = 1'b0;
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (rd_valid !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL empty_end got v=%b count=%0d want 0 0", rd_valid, count);
         end
      end
   endtask

   task automatic test_end_with_write;
      logic [DW-1:0] v [$];
      v = '{16'h1234, 16'hBEEF, 16'h0F0F, 16'hC001};
      write_map(v, 1, 0);
      build_expected(4);
      drain_map(4, 2, 0, 0, "end_with_write");
   endtask

   task automatic test_overflow;
      logic [DW-1:0] v [$];
      for (int i = 1; i <= 9; i++) v.push_back(DW'(i));
      write_map(v, 0, 0);
      build_expected(9);
      drain_map(9, 0, 0, 1, "overflow_drain");
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_set got %b want 1", overflow);
      end
      v.delete();
      for (int i = 0; i < 9; i++) v.push_back(DW'($urandom_range(0, 16'hFFFF)));
      write_map(v, 0, 0);
      build_expected(9);
      drain_map(9, 2, 0, 0, "overflow_next");
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sticky got %b want 1", overflow);
      end
   endtask

   task automatic test_reset_mid_drain;
      logic [DW-1:0] v [$];
      for (int i = 0; i < 9; i++) v.push_back(DW'($urandom_range(0, 16'hFFFF)));
      write_map(v, 0, 0);
      build_expected(9);
      drain_map(9, 0, 4, 0, "pre_abort");
      global_rst = 1'b0;
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0 || count !== '0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL abort_reset got v=%b count=%0d ovf=%b want 0 0 0", rd_valid, count, overflow);
      end
      global_rst = 1'b1;
      @(negedge clk);
      v.delete();
      for (int i = 10; i <= 18; i++) v.push_back(DW'(i));
      write_map(v, 0, 0);
      build_expected(9);
      drain_map(9, 0, 0, 0, "after_abort");
   endtask

   task automatic test_random;
      logic [DW-1:0] v [$];
      int            len, mode;
      for (int t = 0; t < 8; t++) begin
         v.delete();
         len = $urandom_range(1, DEPTH);
         for (int i = 0; i < len; i++) v.push_back(DW'($urandom_range(0, 16'hFFFF)));
         mode = (len == DEPTH) ? $urandom_range(0, 1) : $urandom_range(1, 2);
         write_map(v, mode, 1);
         build_expected(len);
         drain_map(len, 2, 0, 0, "random");
      end
   endtask

   initial begin
      clk        = 1'b0;
      global_rst = 1'b0;
      wr_valid   = 1'b0;
      wr_data    = '0;
      wr_end     = 1'b0;
      rd_ready   = 1'b0;
      checks     = 0;
      errors     = 0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      test_reset;
      test_full_map;
      test_backpressure;
      test_short_map;
      test_empty_end;
      test_end_with_write;
      test_overflow;
      test_reset_mid_drain;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
